// File: rtl/fir_result_quantizer_if.sv
// Output sample stream of the FIR result quantizer: done/data capture inputs
// plus the valid/ready sample stream toward the DAC side.
interface fir_result_quantizer_if;
    logic               doneIn;
    logic signed [35:0] dataIn;
    logic               readyIn;
    logic               validOut;
    logic signed [15:0] dataOut;

    modport master (
        input  doneIn,
        input  dataIn,
        input  readyIn,
        output validOut,
        output dataOut
    );

    modport slave (
        output doneIn,
        output dataIn,
        output readyIn,
        input  validOut,
        input  dataOut
    );
endinterface

// File: rtl/fir_result_quantizer.sv
// Rounds/scales/saturates 36-bit FIR accumulator results to 16-bit samples and buffers them in a show-ahead FIFO.
// Optional clip counter (satCountOut) is built when FIR_QUANT_SAT_COUNT_EN is defined.
module fir_result_quantizer #(
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clkIn,
    input  logic                          nResetIn,
    input  logic                          clearIn,
    fir_result_quantizer_if.master        bus,
    output logic                          overflowOut,
    output logic [$clog2(FIFO_DEPTH):0]   levelOut
`ifdef FIR_QUANT_SAT_COUNT_EN
    ,
    output logic [15:0]                   satCountOut
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [36:0] ROUND_BIAS = 37'sd1 <<< (SHIFT - 1);

    function automatic logic signed [36:0] roundHalfUp(input logic signed [35:0] acc);
        return $signed({acc[35], acc}) + ROUND_BIAS;
    endfunction

    function automatic logic signed [15:0] saturate16(input logic signed [36:0] v);
        logic signed [36:0] scaled;
        scaled = v >>> SHIFT;
        if (scaled > 37'sd32767)       return 16'sh7FFF;
        else if (scaled < -37'sd32768) return 16'sh8000;
        else                           return scaled[15:0];
    endfunction

    function automatic logic isClipped(input logic signed [36:0] v);
        logic signed [36:0] scaled;
        scaled = v >>> SHIFT;
        return (scaled > 37'sd32767) || (scaled < -37'sd32768);
    endfunction

    logic signed [36:0] roundP1;
    logic               vldP1;
    logic signed [15:0] resultP2;
    logic               vldP2;

    logic signed [15:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic [LW-1:0]      level;
    logic signed [15:0] lastData;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = bus.validOut && bus.readyIn;
    assign push = vldP2 && (!full || pop);
    assign drop = vldP2 && full && !pop;

    // Stage 1 / stage 2 datapath: capture with rounding bias, then scale and clip
    always_ff @(posedge clkIn) begin
        if (bus.doneIn) roundP1  <= roundHalfUp(bus.dataIn);
        if (vldP1)      resultP2 <= saturate16(roundP1);
    end

    // FIFO write, one cycle after stage 2
    always_ff @(posedge clkIn) begin
        if (push && !clearIn) mem[wrPtr] <= resultP2;
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            vldP1       <= 1'b0;
            vldP2       <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            level       <= '0;
            overflowOut <= 1'b0;
            lastData    <= '0;
        end else if (clearIn) begin
            vldP1       <= 1'b0;
            vldP2       <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            level       <= '0;
            overflowOut <= 1'b0;
            lastData    <= '0;
        end else begin
            vldP1 <= bus.doneIn;
            vldP2 <= vldP1;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) overflowOut <= 1'b1;
            // Shadow of the head so dataOut keeps the last sample once drained
            if (level != '0) lastData <= mem[rdPtr];
        end
    end

    assign bus.validOut = (level != '0);
    assign bus.dataOut  = (level != '0) ? mem[rdPtr] : lastData;
    assign levelOut     = level;

`ifdef FIR_QUANT_SAT_COUNT_EN
    // Counts clips at stage 2, independent of whether the FIFO accepts them
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            satCountOut <= '0;
        end else if (clearIn) begin
            satCountOut <= '0;
        end else if (vldP1 && isClipped(roundP1) && (satCountOut != 16'hFFFF)) begin
            satCountOut <= satCountOut + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_result_quantizer.sv
// Directed bench for fir_result_quantizer: table-driven rounding/saturation plus hand-written FIFO, clear and reset sequences.
module tb_fir_result_quantizer;

    logic       clkIn;
    logic       nResetIn;
    logic       clearIn;
    logic       overflowOut;
    logic [2:0] levelOut;
`ifdef FIR_QUANT_SAT_COUNT_EN
    logic [15:0] satCountOut;
`endif

    fir_result_quantizer_if bus ();

    fir_result_quantizer #(.SHIFT(15), .FIFO_DEPTH(4)) dut (
        .clkIn       (clkIn),
        .nResetIn    (nResetIn),
        .clearIn     (clearIn),
        .bus         (bus),
        .overflowOut (overflowOut),
        .levelOut    (levelOut)
`ifdef FIR_QUANT_SAT_COUNT_EN
        ,
        .satCountOut (satCountOut)
`endif
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [35:0] din;
        logic signed [15:0] dout;
        logic               clip;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    initial begin
        int expClips;
        vecs[0] = '{36'sd16384,        16'sd1,      1'b0};
        vecs[1] = '{36'sd16383,        16'sd0,      1'b0};
        vecs[2] = '{-36'sd16384,       16'sd0,      1'b0};
        vecs[3] = '{-36'sd16385,       -16'sd1,     1'b0};
        vecs[4] = '{36'sd98304,        16'sd3,      1'b0};
        vecs[5] = '{36'sd2147483648,   16'sh7FFF,   1'b1};
        vecs[6] = '{36'sh800000000,    16'sh8000,   1'b1};
        vecs[7] = '{36'sd1073709056,   16'sh7FFF,   1'b0};
        vecs[8] = '{-36'sd1073741824,  16'sh8000,   1'b0};
        vecs[9] = '{36'sd1073725440,   16'sh7FFF,   1'b1};

        nResetIn    = 1'b0;
        clearIn     = 1'b0;
        bus.doneIn  = 1'b0;
        bus.dataIn  = '0;
        bus.readyIn = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(bus.validOut), 64'(1'b0));
        check("rst_data",  64'(bus.dataOut),  64'(16'h0000));
        check("rst_ovf",   64'(overflowOut),  64'(1'b0));
        check("rst_level", 64'(levelOut),     64'(3'd0));
        nResetIn = 1'b1;
        tick();

        // Rounding and saturation table, one result at a time with readyIn high
        bus.readyIn = 1'b1;
        expClips = 0;
        for (int i = 0; i < 10; i++) begin
            bus.doneIn = 1'b1;
            bus.dataIn = vecs[i].din;
            tick();
            bus.doneIn = 1'b0;
            tick();
            check($sformatf("lat_early[%0d]", i), 64'(bus.validOut), 64'(1'b0));
            tick();
            check($sformatf("lat_valid[%0d]", i), 64'(bus.validOut), 64'(1'b1));
            check($sformatf("value[%0d]", i),     64'(bus.dataOut),  64'(vecs[i].dout));
            tick();
            check($sformatf("drained[%0d]", i),   64'(bus.validOut), 64'(1'b0));
            check($sformatf("hold[%0d]", i),      64'(bus.dataOut),  64'(vecs[i].dout));
            if (vecs[i].clip) expClips++;
        end
`ifdef FIR_QUANT_SAT_COUNT_EN
        check("sat_count", 64'(satCountOut), 64'(expClips));
`endif

        // Back-pressure: five results into a four-entry FIFO
        bus.readyIn = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.doneIn = 1'b1;
            bus.dataIn = 36'(k * 32768);
            tick();
        end
        bus.doneIn = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("bp_level", 64'(levelOut),    64'(3'd4));
        check("bp_ovf",   64'(overflowOut), 64'(1'b1));
        bus.readyIn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("bp_valid[%0d]", k), 64'(bus.validOut), 64'(1'b1));
            check($sformatf("bp_pop[%0d]", k),   64'(bus.dataOut),  64'(16'(k)));
            tick();
        end
        check("bp_empty",    64'(bus.validOut), 64'(1'b0));
        check("bp_ovf_keep", 64'(overflowOut),  64'(1'b1));

        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        check("clr_ovf", 64'(overflowOut), 64'(1'b0));

        // Push landing in the same cycle as a pop while full
        bus.readyIn = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            bus.doneIn = 1'b1;
            bus.dataIn = 36'(k * 32768);
            tick();
        end
        bus.doneIn = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("pp_full", 64'(levelOut), 64'(3'd4));
        bus.doneIn = 1'b1;
        bus.dataIn = 36'(7 * 32768);
        tick();
        bus.doneIn = 1'b0;
        tick();
        bus.readyIn = 1'b1;
        tick();
        bus.readyIn = 1'b0;
        check("pp_level", 64'(levelOut),    64'(3'd4));
        check("pp_ovf",   64'(overflowOut), 64'(1'b0));
        check("pp_head",  64'(bus.dataOut), 64'(16'd11));
        bus.readyIn = 1'b1;
        tick();
        tick();
        tick();
        check("pp_last", 64'(bus.dataOut),  64'(16'd7));
        check("pp_lastv", 64'(bus.validOut), 64'(1'b1));
        tick();
        check("pp_empty", 64'(bus.validOut), 64'(1'b0));

        // clearIn together with doneIn while holding two entries
        bus.readyIn = 1'b0;
        for (int k = 5; k <= 6; k++) begin
            bus.doneIn = 1'b1;
            bus.dataIn = 36'(k * 32768);
            tick();
        end
        bus.doneIn = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("cl_pre", 64'(levelOut), 64'(3'd2));
        clearIn    = 1'b1;
        bus.doneIn = 1'b1;
        bus.dataIn = 36'(9 * 32768);
        tick();
        clearIn    = 1'b0;
        bus.doneIn = 1'b0;
        check("cl_level", 64'(levelOut),     64'(3'd0));
        check("cl_valid", 64'(bus.validOut), 64'(1'b0));
        check("cl_data",  64'(bus.dataOut),  64'(16'h0000));
        check("cl_ovf",   64'(overflowOut),  64'(1'b0));
        bus.readyIn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("cl_quiet[%0d]", c), 64'(bus.validOut), 64'(1'b0));
        end

        // Asynchronous reset with one sample stored and one in flight
        bus.readyIn = 1'b0;
        bus.doneIn  = 1'b1;
        bus.dataIn  = 36'(15 * 32768);
        tick();
        bus.doneIn = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("ar_pre", 64'(bus.dataOut), 64'(16'd15));
        bus.doneIn = 1'b1;
        bus.dataIn = 36'(20 * 32768);
        tick();
        bus.doneIn = 1'b0;
        #3;
        nResetIn = 1'b0;
        #1;
        check("ar_valid", 64'(bus.validOut), 64'(1'b0));
        check("ar_data",  64'(bus.dataOut),  64'(16'h0000));
        check("ar_level", 64'(levelOut),     64'(3'd0));
        check("ar_ovf",   64'(overflowOut),  64'(1'b0));
        @(posedge clkIn);
        @(posedge clkIn);
        #3;
        nResetIn    = 1'b1;
        bus.readyIn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("ar_quiet[%0d]", c), 64'(bus.validOut), 64'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_result_quantizer.md
Name: fir_result_quantizer

Overview:
- Sits directly downstream of the 16-bit 8x8 FIR filter core. It captures the 36-bit signed accumulator on each done pulse, rounds and scales it to a 16-bit signed sample, and saturates the result.
- Results are buffered in a small show-ahead FIFO and presented on a valid/ready stream to the DAC/output interface.
- A sticky overflow flag is raised when results are lost because the FIFO is full.

Parameters:
- SHIFT, 15, right-shift applied to the accumulator; 15 matches Q15 coefficients; legal range 1..20.
- FIFO_DEPTH, 4, number of 16-bit output entries; power of two, >= 2.

Ports:
- clkIn  input  1  system clock; all logic on the rising edge.
- nResetIn  input  1  asynchronous, active-low reset.
- doneIn  input  1  one-cycle pulse from the filter; dataIn is valid in that cycle.
- dataIn  input  36  filter accumulator, two's-complement signed.
- clearIn  input  1  synchronous; flushes the FIFO and clears overflowOut.
- readyIn  input  1  downstream consumer accepts dataOut this cycle.
- validOut  output  1  FIFO head is valid.
- dataOut  output  16  FIFO head, signed sample.
- overflowOut  output  1  sticky; set when a result is dropped.
- levelOut  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (nResetIn low, asynchronous): validOut=0, dataOut=0, overflowOut=0, levelOut=0, pipeline valid bits=0, FIFO pointers=0.
  - Reset mid-operation discards every in-flight and stored result.
- Stage 1 (capture), when doneIn=1:
  - roundReg <= dataIn + (1 << (SHIFT-1)), computed in 37-bit signed to avoid wrap.
  - s1Valid <= 1; otherwise s1Valid <= 0.
- Stage 2 (scale/saturate), when s1Valid=1:
  - Arithmetic shift right: scaled = roundReg >>> SHIFT. Rounding is round-half-up toward +inf.
  - If scaled > 32767, the result is 32767 (0x7FFF).
  - If scaled < -32768, the result is -32768 (0x8000).
  - Otherwise the result is scaled[15:0].
  - s2Valid <= 1.
- Push: the FIFO write occurs in the cycle after stage 2, using s2Valid and the registered result.
- Latency: doneIn in cycle N -> validOut=1 with the sample on dataOut in cycle N+3, if the FIFO was empty.
- Throughput: a result may arrive every cycle. The filter produces one every ~3x128 cycles, so back-pressure only matters when readyIn is held low.
- FIFO (show-ahead):
  - dataOut always reflects the head entry.
  - validOut = (level != 0).
  - A pop happens when validOut && readyIn.
  - dataOut holds its last value when the FIFO is empty. It is not forced to 0, except at reset and clearIn.
- Boundary conditions:
  - Push and pop in the same cycle when full: both occur, level is unchanged, no drop.
  - Push and pop in the same cycle when empty: no pop (validOut=0); the push lands and validOut rises next cycle.
  - Push when full without a pop: the new result is discarded, FIFO contents are untouched, and overflowOut <= 1 (sticky).
  - Pointers wrap modulo FIFO_DEPTH. levelOut ranges 0..FIFO_DEPTH.
- clearIn:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Resets the pointers, levelOut, overflowOut, s1Valid and s2Valid to 0, and sets dataOut to 0.
  - A doneIn in the same cycle as clearIn is discarded.
- No dependency on the filter's busy output. doneIn alone qualifies dataIn.

Optional Feature:
- Macro: FIR_QUANT_SAT_COUNT_EN.
- When defined:
  - Adds output port satCountOut [15:0].
  - The counter increments by 1 for each stage-2 result that was clipped (either rail).
  - It saturates at 0xFFFF (no wrap).
  - It is cleared by reset and by clearIn.
  - It counts clipped results even if they are later dropped by a full FIFO.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Rounding, SHIFT=15, readyIn=1:
  - dataIn=16384 -> dataOut=1.
  - dataIn=16383 -> 0.
  - dataIn=-16384 -> 0.
  - dataIn=-16385 -> -1 (0xFFFF).
  - dataIn=98304 -> 3.
  - Each result appears exactly 3 cycles after its doneIn.
- Saturation:
  - dataIn=2^31 -> 0x7FFF.
  - dataIn=-2^35 -> 0x8000.
  - With FIR_QUANT_SAT_COUNT_EN defined, satCountOut=2 afterwards.
- Back-pressure and overflow: readyIn=0, five doneIn pulses with values k*32768 for k=1..5.
  - Expect levelOut=4 and overflowOut=1.
  - Then raise readyIn: pops yield 1,2,3,4 in order, validOut falls, and overflowOut stays 1.
- Simultaneous push/pop when full: fill to 4 entries, then assert doneIn (value 7*32768) timed so its push lands in a cycle where readyIn=1 pops.
  - levelOut stays 4, overflowOut stays 0, and 7 appears as the last sample.
- clearIn with doneIn in the same cycle while holding 2 entries:
  - Next cycle levelOut=0, validOut=0, dataOut=0, overflowOut=0.
  - No sample appears during the following 5 cycles.
- Asynchronous reset mid-pipeline: pulse doneIn, then drop nResetIn one cycle later, not aligned to a clock edge.
  - All outputs go to 0 immediately.
  - After release, no stale sample is ever presented.
